// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction SRAM port plus the IF-to-ID handshake and branch redirect
interface fetch_stage_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_zip;
  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, if_to_id_valid, if_to_id_zip,
    input  inst_sram_rdata, id_allowin, br_taken, br_target
  );
  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, if_to_id_valid, if_to_id_zip,
    output inst_sram_rdata, id_allowin, br_taken, br_target
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: pre-IF/IF stage, drives the 1-cycle instruction SRAM and buffers the fetched word under decode stalls
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic            clk,
  input logic            resetn,
  fetch_stage_if.master  bus
);
  logic        if_valid_q, if_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        if_allowin, req, capture;
  logic [31:0] next_pc;
  assign if_allowin = ~if_valid_q | bus.id_allowin | bus.br_taken;
  assign next_pc    = bus.br_taken ? bus.br_target : if_pc_q + 32'd4;
  assign req        = resetn & if_allowin;
  // SRAM data lives for one cycle only, so hold it while decode stalls
  assign capture    = if_valid_q & ~buf_valid_q & ~bus.id_allowin & ~bus.br_taken;
  always_comb begin
    if_valid_d  = req ? 1'b1 : if_valid_q;
    if_pc_d     = req ? next_pc : if_pc_q;
    buf_valid_d = req ? 1'b0 : (capture ? 1'b1 : buf_valid_q);
    inst_buf_d  = capture ? bus.inst_sram_rdata : inst_buf_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      if_pc_q     <= RESET_PC - 32'd4;
      inst_buf_q  <= 32'd0;
    end else begin
      if_valid_q  <= if_valid_d;
      buf_valid_q <= buf_valid_d;
      if_pc_q     <= if_pc_d;
      inst_buf_q  <= inst_buf_d;
    end
  end
  assign bus.inst_sram_en    = req;
  assign bus.inst_sram_we    = 4'b0;
  assign bus.inst_sram_addr  = next_pc;
  assign bus.inst_sram_wdata = 32'b0;
  assign bus.if_to_id_valid  = resetn & if_valid_q & ~bus.br_taken;
  assign bus.if_to_id_zip    = {buf_valid_q ? inst_buf_q : bus.inst_sram_rdata, if_pc_q};
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic checked against an address-level model of the fetch stage
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = RESET_PC - 32'd4;
  logic        prev_r = 1'b0, prev_en = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  fetch_stage_if bus();
  fetch_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask
  task automatic cycle(input logic r, input logic a, input logic b, input logic [31:0] t);
    logic        e_en, e_val;
    logic [31:0] e_addr;
    @(posedge clk);
    if (!prev_r) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
    end else if (prev_en) begin
      m_valid = 1'b1;
      m_pc    = prev_addr;
    end
    #1;
    resetn = r;
    bus.id_allowin = a;
    bus.br_taken = b;
    bus.br_target = t;
    bus.inst_sram_rdata = pend ? mem(pend_addr) : $urandom;
    #3;
    e_en   = r & (~m_valid | a | b);
    e_addr = b ? t : m_pc + 32'd4;
    e_val  = r & m_valid & ~b;
    chk("en", {63'd0, bus.inst_sram_en}, {63'd0, e_en});
    chk("addr", {32'd0, bus.inst_sram_addr}, {32'd0, e_addr});
    chk("valid", {63'd0, bus.if_to_id_valid}, {63'd0, e_val});
    if (e_val) chk("zip", bus.if_to_id_zip, {mem(m_pc), m_pc});
    chk("we_wdata", {28'd0, bus.inst_sram_we, bus.inst_sram_wdata}, 64'd0);
    pend      = bus.inst_sram_en;
    pend_addr = bus.inst_sram_addr;
    prev_r    = r;
    prev_en   = e_en;
    prev_addr = e_addr;
  endtask
  initial begin
    bus.id_allowin = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.inst_sram_rdata = '0;
    repeat (3) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("first_req", {32'd0, bus.inst_sram_addr}, {32'd0, RESET_PC});
    cycle(1, 1, 0, 0);
    chk("first_pc", {32'd0, bus.if_to_id_zip[31:0]}, {32'd0, RESET_PC});
    cycle(1, 1, 0, 0);
    repeat (4) cycle(1, 0, 0, 0);
    chk("stall_pc", {32'd0, bus.if_to_id_zip[31:0]}, 64'h1c000008);
    cycle(1, 1, 0, 0);
    chk("after_stall", {32'd0, bus.inst_sram_addr}, 64'h1c00000c);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h1c000100);
    chk("br_pc_held", {32'd0, bus.if_to_id_zip[31:0]}, 64'h1c000010);
    cycle(1, 1, 0, 0);
    chk("br_deliver", {32'd0, bus.if_to_id_zip[31:0]}, 64'h1c000100);
    repeat (3) cycle(1, 0, 1, 32'h1c000200);
    cycle(1, 0, 0, 0);
    chk("br3_deliver", {32'd0, bus.if_to_id_zip[31:0]}, 64'h1c000200);
    cycle(1, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    chk("reset_req", {32'd0, bus.inst_sram_addr}, {32'd0, RESET_PC});
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(63) != 0, $urandom_range(1), $urandom_range(5) == 0,
            $urandom_range(7) == 0 ? 32'hfffffffc : $urandom);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
